// File: rtl/lab06_issuer.sv
// lab06_issuer: host-side transmitter for the lab06 operand interface.
// Buffers operands in a small FIFO, streams them as one contiguous in_valid
// burst on start (mode on the first beat only), then waits for the consumer's
// out_valid and reports either the captured signed result or a timeout.
module lab06_issuer #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [3:0]                 wr_number,
  input  logic                       start,
  input  logic [1:0]                 start_mode,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       in_valid,
  output logic [3:0]                 in_number,
  output logic [1:0]                 mode,
  input  logic                       out_valid,
  input  logic [5:0]                 out_result,
  output logic                       rsp_valid,
  output logic                       rsp_timeout,
  output logic [5:0]                 rsp_result
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT-1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [3:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    state_q, state_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          busy_q, busy_d;
  logic          in_valid_q, in_valid_d;
  logic [3:0]    in_number_q, in_number_d;
  logic [1:0]    mode_q, mode_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_timeout_q, rsp_timeout_d;
  logic [5:0]    rsp_result_q, rsp_result_d;

  logic          wr_ok;
  logic          pop;
  logic [3:0]    head;

  // Writes only land while idle and not full; an empty FIFO forwards the
  // same-cycle write so write+start yields a burst carrying that value.
  assign wr_ok = (state_q == S_IDLE) && wr_en && (count_q < DEPTH_C);
  assign head  = (count_q == '0) ? wr_number : mem_q[rd_ptr_q];

  // Operand storage; the written slot is also the one popped in the bypass case.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_number;
  end

  // Next-state logic for the issuer FSM, FIFO bookkeeping and output registers.
  always_comb begin
    state_d       = state_q;
    busy_d        = busy_q;
    tcnt_d        = tcnt_q;
    in_valid_d    = 1'b0;
    in_number_d   = 4'd0;
    mode_d        = 2'd0;
    rsp_valid_d   = 1'b0;
    rsp_timeout_d = 1'b0;
    rsp_result_d  = rsp_result_q;
    pop           = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && ((count_q != '0) || wr_ok)) begin
          state_d     = S_SEND;
          busy_d      = 1'b1;
          pop         = 1'b1;
          in_valid_d  = 1'b1;
          in_number_d = head;
          mode_d      = start_mode;
        end
      end
      S_SEND: begin
        if (count_q != '0) begin
          pop         = 1'b1;
          in_valid_d  = 1'b1;
          in_number_d = head;
        end else begin
          state_d = S_WAIT;
          tcnt_d  = '0;
        end
      end
      S_WAIT: begin
        // A result arriving on the final allowed cycle still beats the timeout.
        if (out_valid) begin
          rsp_result_d = out_result;
          rsp_valid_d  = 1'b1;
          state_d      = S_IDLE;
          busy_d       = 1'b0;
          tcnt_d       = '0;
        end else if (tcnt_q == T_LAST) begin
          rsp_timeout_d = 1'b1;
          state_d       = S_IDLE;
          busy_d        = 1'b0;
          tcnt_d        = '0;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
      count_d  = count_d + CW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      count_d  = count_d - CW'(1);
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      tcnt_q        <= '0;
      busy_q        <= 1'b0;
      in_valid_q    <= 1'b0;
      in_number_q   <= 4'd0;
      mode_q        <= 2'd0;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_result_q  <= 6'd0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      tcnt_q        <= tcnt_d;
      busy_q        <= busy_d;
      in_valid_q    <= in_valid_d;
      in_number_q   <= in_number_d;
      mode_q        <= mode_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_result_q  <= rsp_result_d;
    end
  end

  assign busy        = busy_q;
  assign count       = count_q;
  assign in_valid    = in_valid_q;
  assign in_number   = in_number_q;
  assign mode        = mode_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_timeout = rsp_timeout_q;
  assign rsp_result  = rsp_result_q;

endmodule

// File: tb/tb_lab06_issuer.sv
// Directed testbench for lab06_issuer: a cycle table for the basic burst and
// response, plus hand-written sequences for the multi-cycle corner cases.
module tb_lab06_issuer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [3:0] wr_number;
  logic       start;
  logic [1:0] start_mode;
  logic       busy;
  logic [3:0] count;
  logic       in_valid;
  logic [3:0] in_number;
  logic [1:0] mode;
  logic       out_valid;
  logic [5:0] out_result;
  logic       rsp_valid;
  logic       rsp_timeout;
  logic [5:0] rsp_result;

  int checks   = 0;
  int failures = 0;

  lab06_issuer #(.DEPTH(8), .TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_number(wr_number),
    .start(start), .start_mode(start_mode), .busy(busy), .count(count),
    .in_valid(in_valid), .in_number(in_number), .mode(mode),
    .out_valid(out_valid), .out_result(out_result), .rsp_valid(rsp_valid),
    .rsp_timeout(rsp_timeout), .rsp_result(rsp_result)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       wr_en;
    logic [3:0] wr_number;
    logic       start;
    logic [1:0] start_mode;
    logic       out_valid;
    logic [5:0] out_result;
    logic       e_busy;
    logic [3:0] e_count;
    logic       e_in_valid;
    logic [3:0] e_in_number;
    logic [1:0] e_mode;
    logic       e_rsp_valid;
    logic       e_rsp_timeout;
    logic [5:0] e_rsp_result;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; wr_number = 4'd0; start = 1'b0; start_mode = 2'd0;
    out_valid = 1'b0; out_result = 6'd0;
  endtask

  initial begin
    int nb;
    int k;
    int pulses;

    rst_n = 1'b0;
    idle_inputs();
    step();
    step();
    $display("reset: busy=%0d count=%0d in_valid=%0d rsp_result=%0h", busy, count, in_valid, rsp_result);
    chk("rst_busy", busy, 0);
    chk("rst_count", count, 0);
    chk("rst_in_valid", in_valid, 0);
    chk("rst_in_number", in_number, 0);
    chk("rst_mode", mode, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_timeout", rsp_timeout, 0);
    chk("rst_rsp_result", rsp_result, 0);
    rst_n = 1'b1;

    // Write 3,7,12; start mode 2 (with a busy-time start/write that must be
    // ignored); out_valid during SEND ignored; result -5 two cycles after the
    // last beat; a later out_valid in IDLE ignored.
    //           wr num  st md ov res     bsy cnt iv num md rv rt res
    vecs[0]  = '{1'b1, 4'd3,  1'b0, 2'd0, 1'b0, 6'h00, 1'b0, 4'd1, 1'b0, 4'd0,  2'd0, 1'b0, 1'b0, 6'h00};
    vecs[1]  = '{1'b1, 4'd7,  1'b0, 2'd0, 1'b0, 6'h00, 1'b0, 4'd2, 1'b0, 4'd0,  2'd0, 1'b0, 1'b0, 6'h00};
    vecs[2]  = '{1'b1, 4'd12, 1'b0, 2'd0, 1'b0, 6'h00, 1'b0, 4'd3, 1'b0, 4'd0,  2'd0, 1'b0, 1'b0, 6'h00};
    vecs[3]  = '{1'b0, 4'd0,  1'b1, 2'd2, 1'b0, 6'h00, 1'b1, 4'd2, 1'b1, 4'd3,  2'd2, 1'b0, 1'b0, 6'h00};
    vecs[4]  = '{1'b1, 4'd9,  1'b1, 2'd3, 1'b0, 6'h00, 1'b1, 4'd1, 1'b1, 4'd7,  2'd0, 1'b0, 1'b0, 6'h00};
    vecs[5]  = '{1'b0, 4'd0,  1'b0, 2'd0, 1'b1, 6'h01, 1'b1, 4'd0, 1'b1, 4'd12, 2'd0, 1'b0, 1'b0, 6'h00};
    vecs[6]  = '{1'b0, 4'd0,  1'b0, 2'd0, 1'b0, 6'h00, 1'b1, 4'd0, 1'b0, 4'd0,  2'd0, 1'b0, 1'b0, 6'h00};
    vecs[7]  = '{1'b0, 4'd0,  1'b0, 2'd0, 1'b0, 6'h00, 1'b1, 4'd0, 1'b0, 4'd0,  2'd0, 1'b0, 1'b0, 6'h00};
    vecs[8]  = '{1'b0, 4'd0,  1'b0, 2'd0, 1'b1, 6'h3B, 1'b0, 4'd0, 1'b0, 4'd0,  2'd0, 1'b1, 1'b0, 6'h3B};
    vecs[9]  = '{1'b0, 4'd0,  1'b0, 2'd0, 1'b0, 6'h00, 1'b0, 4'd0, 1'b0, 4'd0,  2'd0, 1'b0, 1'b0, 6'h3B};
    vecs[10] = '{1'b0, 4'd0,  1'b0, 2'd0, 1'b1, 6'h15, 1'b0, 4'd0, 1'b0, 4'd0,  2'd0, 1'b0, 1'b0, 6'h3B};

    for (int i = 0; i < 11; i++) begin
      wr_en = vecs[i].wr_en; wr_number = vecs[i].wr_number;
      start = vecs[i].start; start_mode = vecs[i].start_mode;
      out_valid = vecs[i].out_valid; out_result = vecs[i].out_result;
      step();
      $display("vec %0d: busy=%0d count=%0d iv=%0d num=%0d mode=%0d rv=%0d rt=%0d res=%0h",
               i, busy, count, in_valid, in_number, mode, rsp_valid, rsp_timeout, rsp_result);
      chk($sformatf("v%0d_busy", i), busy, vecs[i].e_busy);
      chk($sformatf("v%0d_count", i), count, vecs[i].e_count);
      chk($sformatf("v%0d_in_valid", i), in_valid, vecs[i].e_in_valid);
      chk($sformatf("v%0d_in_number", i), in_number, vecs[i].e_in_number);
      chk($sformatf("v%0d_mode", i), mode, vecs[i].e_mode);
      chk($sformatf("v%0d_rsp_valid", i), rsp_valid, vecs[i].e_rsp_valid);
      chk($sformatf("v%0d_rsp_timeout", i), rsp_timeout, vecs[i].e_rsp_timeout);
      chk($sformatf("v%0d_rsp_result", i), rsp_result, vecs[i].e_rsp_result);
    end
    idle_inputs();

    // Nine writes into an 8-deep FIFO: ninth dropped, exactly 8 beats 1..8.
    for (int i = 1; i <= 9; i++) begin
      wr_en = 1'b1; wr_number = 4'(i);
      step();
    end
    wr_en = 1'b0;
    $display("full: count=%0d", count);
    chk("full_count", count, 8);
    start = 1'b1; start_mode = 2'd1;
    step();
    start = 1'b0;
    nb = 0;
    for (int c = 0; c < 20; c++) begin
      if (in_valid) begin
        $display("full beat %0d: num=%0d mode=%0d", nb, in_number, mode);
        chk("full_beat_num", in_number, nb + 1);
        chk("full_beat_mode", mode, (nb == 0) ? 1 : 0);
        nb++;
      end else if (nb > 0) begin
        break;
      end
      step();
    end
    chk("full_nbeats", nb, 8);
    out_valid = 1'b1; out_result = 6'h05;
    step();
    out_valid = 1'b0;
    $display("full rsp: rv=%0d res=%0h busy=%0d", rsp_valid, rsp_result, busy);
    chk("full_rsp_valid", rsp_valid, 1);
    chk("full_rsp_result", rsp_result, 6'h05);
    chk("full_busy", busy, 0);

    // One-operand burst with no response: timeout 64 cycles after WAIT entry.
    wr_en = 1'b1; wr_number = 4'd4;
    step();
    wr_en = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    k = 0;
    pulses = 0;
    for (int c = 1; c <= 100; c++) begin
      step();
      if (rsp_valid) pulses++;
      if (rsp_timeout) begin
        k = c;
        break;
      end
    end
    $display("timeout: edges=%0d res=%0h busy=%0d", k, rsp_result, busy);
    chk("to_edges", k, 65);
    chk("to_no_rsp_valid", pulses, 0);
    chk("to_rsp_result", rsp_result, 6'h05);
    chk("to_busy", busy, 0);
    step();
    chk("to_pulse_width", rsp_timeout, 0);

    // Write and start together on an empty FIFO, then out_valid held 3 cycles.
    wr_en = 1'b1; wr_number = 4'd5; start = 1'b1; start_mode = 2'd3;
    step();
    idle_inputs();
    $display("wr+start: iv=%0d num=%0d mode=%0d count=%0d busy=%0d", in_valid, in_number, mode, count, busy);
    chk("ws_in_valid", in_valid, 1);
    chk("ws_in_number", in_number, 5);
    chk("ws_mode", mode, 3);
    chk("ws_count", count, 0);
    chk("ws_busy", busy, 1);
    step();
    chk("ws_single_beat", in_valid, 0);
    out_valid = 1'b1; out_result = 6'h10;
    pulses = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (rsp_valid) pulses++;
      out_result = 6'h20;
    end
    out_valid = 1'b0;
    $display("hold3: pulses=%0d res=%0h busy=%0d", pulses, rsp_result, busy);
    chk("hold3_pulses", pulses, 1);
    chk("hold3_result", rsp_result, 6'h10);
    chk("hold3_busy", busy, 0);

    // Start on an empty FIFO is ignored.
    start = 1'b1; start_mode = 2'd2;
    step();
    start = 1'b0;
    $display("empty start: busy=%0d iv=%0d", busy, in_valid);
    chk("empty_busy", busy, 0);
    chk("empty_in_valid", in_valid, 0);
    step();
    chk("empty_in_valid2", in_valid, 0);

    // Reset on the second beat of a 4-beat burst.
    for (int i = 1; i <= 4; i++) begin
      wr_en = 1'b1; wr_number = 4'(i + 10);
      step();
    end
    wr_en = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    chk("rb_beat1", in_number, 11);
    step();
    chk("rb_beat2", in_number, 12);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    $display("mid-burst reset: iv=%0d count=%0d busy=%0d rv=%0d rt=%0d res=%0h",
             in_valid, count, busy, rsp_valid, rsp_timeout, rsp_result);
    chk("rb_in_valid", in_valid, 0);
    chk("rb_count", count, 0);
    chk("rb_busy", busy, 0);
    chk("rb_rsp_result", rsp_result, 0);
    pulses = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (rsp_valid || rsp_timeout || in_valid) pulses++;
    end
    chk("rb_quiet", pulses, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("rb_empty_start_busy", busy, 0);
    chk("rb_empty_start_iv", in_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Response pulses must never coincide.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_timeout) begin
      failures++;
      $display("FAIL rsp_exclusive: rsp_valid=1 rsp_timeout=1 required not both at %0t", $time);
    end
  end

endmodule
